// File: rtl/matmul_pool_pkg.sv
// matmul_pool_pkg: shared state encoding, pool mode codes and width helpers for the matmul/pool engine
package matmul_pool_pkg;
  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_RD_A   = 4'd1;
  localparam logic [3:0] S_WAIT_A = 4'd2;
  localparam logic [3:0] S_RD_B   = 4'd3;
  localparam logic [3:0] S_WAIT_B = 4'd4;
  localparam logic [3:0] S_MAC    = 4'd5;
  localparam logic [3:0] S_STORE  = 4'd6;
  localparam logic [3:0] S_POOL   = 4'd7;
  localparam logic [3:0] S_WRITE  = 4'd8;
  localparam logic [3:0] S_DONE   = 4'd9;
  localparam logic POOL_AVG = 1'b0;
  localparam logic POOL_MAX = 1'b1;
  function automatic int acc_width(input int n, input int dw);
    return 2 * dw + $clog2(n);
  endfunction
  function automatic int pool_dim(input int n, input int p);
    return n / p;
  endfunction
endpackage

// File: rtl/pool_window_unit.sv
// pool_window_unit: reduces one PxP window of full-precision products to a saturated average or maximum
module pool_window_unit
  import matmul_pool_pkg::*;
#(
  parameter int P = 2,
  parameter int DW = 8,
  parameter int ACCW = 18
) (
  input  logic [P*P-1:0][ACCW-1:0] win,
  input  logic                     mode,
  output logic [DW-1:0]            result
);
  localparam int LP = $clog2(P * P);
  localparam int SW = ACCW + LP;
  logic [SW-1:0] sum;
  logic [ACCW-1:0] mx, sel;
  always_comb begin
    sum = '0;
    mx = '0;
    for (int i = 0; i < P * P; i++) begin
      sum = sum + SW'(win[i]);
      mx = win[i] > mx ? win[i] : mx;
    end
    sel = mode == POOL_MAX ? mx : ACCW'(sum >> LP);
    result = |sel[ACCW-1:DW] ? '1 : sel[DW-1:0];
  end
endmodule

// File: rtl/matmul_pool_engine.sv
// matmul_pool_engine: NxN matrix multiply followed by PxP average/max pooling over a simple memory interface
module matmul_pool_engine
  import matmul_pool_pkg::*;
#(
  parameter int N = 4,
  parameter int DW = 8,
  parameter int P = 2,
  parameter int AW = 10,
  parameter logic [AW-1:0] BASE_A = 'h000,
  parameter logic [AW-1:0] BASE_B = 'h100,
  parameter logic [AW-1:0] BASE_C = 'h200
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  kick_start,
  input  logic                  pool_mode,
  output logic                  ready,
  output logic                  done,
  output logic                  mem_en_read_A,
  output logic [AW-1:0]         mem_addr_A,
  input  logic [N*DW-1:0]       mem_data_A,
  output logic                  mem_en_read_B,
  output logic [AW-1:0]         mem_addr_B,
  input  logic [N*DW-1:0]       mem_data_B,
  output logic                  mem_en_write_C,
  output logic [AW-1:0]         mem_addr_C,
  output logic [(N/P)*DW-1:0]   mem_data_C
);
  localparam int ACCW = acc_width(N, DW);
  localparam int NP = pool_dim(N, P);
  localparam int CW = NP * DW;
  localparam int CNW = $clog2(N);
  localparam logic [CNW-1:0] LAST = CNW'(N - 1);
  localparam logic [CNW-1:0] NP_LAST = CNW'(NP - 1);
  logic [3:0] state;
  logic [CNW-1:0] r, c, k, pr, pc, wr;
  logic mode;
  logic [N*DW-1:0] a_buf, b_buf;
  logic [ACCW-1:0] acc;
  logic [ACCW-1:0] c_buf [N][N];
  logic [NP*CW-1:0] pooled;
  logic [P*P-1:0][ACCW-1:0] win;
  logic [DW-1:0] pool_out, a_el, b_el;
  assign a_el = DW'(a_buf >> (int'(k) * DW));
  assign b_el = DW'(b_buf >> (int'(k) * DW));
  always_comb begin
    win = '0;
    for (int i = 0; i < P; i++)
      for (int j = 0; j < P; j++)
        win[i*P+j] = c_buf[CNW'(int'(pr) * P + i)][CNW'(int'(pc) * P + j)];
  end
  pool_window_unit #(.P(P), .DW(DW), .ACCW(ACCW)) u_pool (
    .win(win),
    .mode(mode),
    .result(pool_out)
  );
  assign ready = state == S_IDLE;
  assign done = state == S_DONE;
  assign mem_en_read_A = state == S_RD_A;
  assign mem_en_read_B = state == S_RD_B;
  assign mem_en_write_C = state == S_WRITE;
  assign mem_addr_A = mem_en_read_A ? BASE_A + AW'(r) : '0;
  assign mem_addr_B = mem_en_read_B ? BASE_B + AW'(c) : '0;
  assign mem_addr_C = mem_en_write_C ? BASE_C + AW'(wr) : '0;
  assign mem_data_C = mem_en_write_C ? CW'(pooled >> (int'(wr) * CW)) : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      {r, c, k, pr, pc, wr} <= '0;
      mode <= POOL_AVG;
      a_buf <= '0;
      b_buf <= '0;
      acc <= '0;
      c_buf <= '{default: '0};
      pooled <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          {r, c, k, pr, pc, wr} <= '0;
          a_buf <= '0;
          b_buf <= '0;
          acc <= '0;
          c_buf <= '{default: '0};
          pooled <= '0;
          if (kick_start) begin
            mode <= pool_mode;
            state <= S_RD_A;
          end
        end
        S_RD_A: state <= S_WAIT_A;
        S_WAIT_A: begin
          a_buf <= mem_data_A;
          state <= S_RD_B;
        end
        S_RD_B: state <= S_WAIT_B;
        S_WAIT_B: begin
          b_buf <= mem_data_B;
          acc <= '0;
          k <= '0;
          state <= S_MAC;
        end
        S_MAC: begin
          acc <= acc + ACCW'(a_el) * ACCW'(b_el);
          k <= k + 1'b1;
          if (k == LAST) state <= S_STORE;
        end
        S_STORE: begin
          c_buf[r][c] <= acc;
          if (r == LAST && c == LAST) begin
            {pr, pc} <= '0;
            state <= S_POOL;
          end else if (c == LAST) begin
            r <= r + 1'b1;
            c <= '0;
            state <= S_RD_A;
          end else begin
            c <= c + 1'b1;
            state <= S_RD_B;
          end
        end
        S_POOL: begin
          pooled[(int'(pr) * NP + int'(pc)) * DW +: DW] <= pool_out;
          pc <= pc == NP_LAST ? '0 : pc + 1'b1;
          if (pc == NP_LAST) begin
            pr <= pr + 1'b1;
            if (pr == NP_LAST) begin
              wr <= '0;
              state <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          wr <= wr + 1'b1;
          if (wr == NP_LAST) state <= S_DONE;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matmul_pool_engine.sv
// tb_matmul_pool_engine: scoreboard bench for a default 4x4/2x2 engine and an 8x8/4x4 engine side by side
module tb_matmul_pool_engine;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst = 1;
  logic [1:0] kick = '0, pmode = '0;
  logic [1:0] ready, done, en_rA, en_rB, en_wC;
  logic [9:0] addr_A[2], addr_B[2], addr_C[2];
  logic [15:0] data_C[2];
  logic [31:0] dA0, dB0, memA0[4], memB0[4];
  logic [63:0] dA1, dB1, memA1[8], memB1[8];
  int am[8][8], bm[8][8];
  logic [15:0] exp_row[2];
  logic [26:0] sb[$];
  int total = 0, bad = 0;
  int er[2], ec[2];

  matmul_pool_engine u0 (
    .clk(clk), .rst(rst), .kick_start(kick[0]), .pool_mode(pmode[0]),
    .ready(ready[0]), .done(done[0]),
    .mem_en_read_A(en_rA[0]), .mem_addr_A(addr_A[0]), .mem_data_A(dA0),
    .mem_en_read_B(en_rB[0]), .mem_addr_B(addr_B[0]), .mem_data_B(dB0),
    .mem_en_write_C(en_wC[0]), .mem_addr_C(addr_C[0]), .mem_data_C(data_C[0])
  );
  matmul_pool_engine #(.N(8), .P(4)) u1 (
    .clk(clk), .rst(rst), .kick_start(kick[1]), .pool_mode(pmode[1]),
    .ready(ready[1]), .done(done[1]),
    .mem_en_read_A(en_rA[1]), .mem_addr_A(addr_A[1]), .mem_data_A(dA1),
    .mem_en_read_B(en_rB[1]), .mem_addr_B(addr_B[1]), .mem_data_B(dB1),
    .mem_en_write_C(en_wC[1]), .mem_addr_C(addr_C[1]), .mem_data_C(data_C[1])
  );

  // one-cycle read latency memories
  always @(posedge clk) begin
    if (en_rA[0]) dA0 <= memA0[addr_A[0][1:0]];
    if (en_rB[0]) dB0 <= memB0[addr_B[0][1:0]];
    if (en_rA[1]) dA1 <= memA1[addr_A[1][2:0]];
    if (en_rB[1]) dB1 <= memB1[addr_B[1][2:0]];
  end

  // strobe exclusivity, read address order and write scoreboard
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [26:0] got, e;
      if (ready[i]) begin er[i] = 0; ec[i] = 0; end
      if ({en_rA[i], en_rB[i], en_wC[i]} != 3'b000) begin
        total++;
        if ($countones({en_rA[i], en_rB[i], en_wC[i]}) > 1) begin
          bad++; $display("FAIL strobe_excl u%0d got=%b exp=onehot", i, {en_rA[i], en_rB[i], en_wC[i]});
        end
      end
      if (en_rA[i]) begin
        total++;
        if (addr_A[i] !== 10'(er[i])) begin
          bad++; $display("FAIL rd_a_addr u%0d got=%h exp=%h", i, addr_A[i], 10'(er[i]));
        end
      end
      if (en_rB[i]) begin
        total++;
        if (addr_B[i] !== 10'h100 + 10'(ec[i])) begin
          bad++; $display("FAIL rd_b_addr u%0d got=%h exp=%h", i, addr_B[i], 10'h100 + 10'(ec[i]));
        end
        ec[i]++;
        if (ec[i] == (i == 0 ? 4 : 8)) begin ec[i] = 0; er[i]++; end
      end
      if (en_wC[i]) begin
        total++;
        got = {i[0], addr_C[i], data_C[i]};
        if (sb.size() == 0) begin
          bad++; $display("FAIL wr_unexpected u%0d got=%h exp=none", i, got);
        end else begin
          e = sb.pop_front();
          if (got !== e) begin
            bad++; $display("FAIL wr_c u%0d got=%h exp=%h", i, got, e);
          end
        end
      end
    end
  end

  task automatic load(input int inst);
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < 8; k++) begin
        if (inst == 0 && r < 4 && k < 4) begin
          memA0[r][k*8+:8] = 8'(am[r][k]);
          memB0[r][k*8+:8] = 8'(bm[k][r]);
        end
        if (inst == 1) begin
          memA1[r][k*8+:8] = 8'(am[r][k]);
          memB1[r][k*8+:8] = 8'(bm[k][r]);
        end
      end
  endtask

  task automatic model(input int n, input int p, input bit mx);
    longint cm[8][8];
    longint s, m, v;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        cm[i][j] = 0;
        for (int k = 0; k < n; k++) cm[i][j] += longint'(am[i][k]) * longint'(bm[k][j]);
      end
    for (int wi = 0; wi < n / p; wi++)
      for (int wj = 0; wj < n / p; wj++) begin
        s = 0; m = 0;
        for (int a = 0; a < p; a++)
          for (int b = 0; b < p; b++) begin
            v = cm[wi*p+a][wj*p+b];
            s += v;
            m = v > m ? v : m;
          end
        v = mx ? m : s / (p * p);
        if (v > 255) v = 255;
        exp_row[wi][wj*8+:8] = 8'(v);
      end
  endtask

  task automatic set_identity();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        am[r][c] = (r == c) ? 1 : 0;
        bm[r][c] = 4 * r + c;
      end
    load(0);
  endtask

  task automatic push0(input logic [15:0] w0, input logic [15:0] w1);
    sb.push_back({1'b0, 10'h200, w0});
    sb.push_back({1'b0, 10'h201, w1});
  endtask

  task automatic do_run(input int inst, input bit mode, output int lat, output logic r1, output int w);
    w = 0;
    while (!ready[inst] && w < 1000) begin @(negedge clk); w++; end
    kick[inst] = 1'b1;
    pmode[inst] = mode;
    @(negedge clk);
    kick[inst] = 1'b0;
    r1 = ready[inst];
    lat = 1;
    while (!done[inst] && lat < 2000) begin @(negedge clk); lat++; end
    if (!done[inst]) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({ready[i], done[i], en_rA[i], en_rB[i], en_wC[i]} !== 5'b10000) begin
        bad++; $display("FAIL reset_ctrl u%0d got=%b exp=10000", i, {ready[i], done[i], en_rA[i], en_rB[i], en_wC[i]});
      end
      total++;
      if ({addr_A[i], addr_B[i], addr_C[i], data_C[i]} !== 46'h0) begin
        bad++; $display("FAIL reset_bus u%0d got=%h exp=0", i, {addr_A[i], addr_B[i], addr_C[i], data_C[i]});
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_avg();
    int lat, w;
    logic r1;
    set_identity();
    push0(16'h0402, 16'h0C0A);
    do_run(0, 1'b0, lat, r1, w);
    total++;
    if (lat !== 127) begin bad++; $display("FAIL avg_latency got=%0d exp=127", lat); end
    total++;
    if (r1 !== 1'b0) begin bad++; $display("FAIL ready_drop got=%b exp=0", r1); end
    total++;
    if (sb.size() !== 0) begin bad++; $display("FAIL avg_writes_left got=%0d exp=0", sb.size()); end
  endtask

  task automatic test_max();
    int lat, w;
    logic r1;
    set_identity();
    push0(16'h0705, 16'h0F0D);
    do_run(0, 1'b1, lat, r1, w);
    total++;
    if (lat !== 127) begin bad++; $display("FAIL max_latency got=%0d exp=127", lat); end
    total++;
    if (sb.size() !== 0) begin bad++; $display("FAIL max_writes_left got=%0d exp=0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    int lat, w;
    logic r1;
    set_identity();
    push0(16'h0402, 16'h0C0A);
    do_run(0, 1'b0, lat, r1, w);
    push0(16'h0705, 16'h0F0D);
    do_run(0, 1'b1, lat, r1, w);
    total++;
    if (w !== 1) begin bad++; $display("FAIL b2b_idle_wait got=%0d exp=1", w); end
    total++;
    if (lat !== 127) begin bad++; $display("FAIL b2b_latency got=%0d exp=127", lat); end
    total++;
    if (sb.size() !== 0) begin bad++; $display("FAIL b2b_writes_left got=%0d exp=0", sb.size()); end
  endtask

  task automatic test_saturation();
    int lat, w;
    logic r1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin am[r][c] = 255; bm[r][c] = 255; end
    load(0);
    for (int m = 0; m < 2; m++) begin
      push0(16'hFFFF, 16'hFFFF);
      do_run(0, m[0], lat, r1, w);
      total++;
      if (lat !== 127) begin bad++; $display("FAIL sat_latency mode=%0d got=%0d exp=127", m, lat); end
      total++;
      if (sb.size() !== 0) begin bad++; $display("FAIL sat_writes_left mode=%0d got=%0d exp=0", m, sb.size()); end
    end
  endtask

  task automatic test_kick_held();
    int lat = 1, w = 0;
    set_identity();
    push0(16'h0705, 16'h0F0D);
    while (!ready[0] && w < 1000) begin @(negedge clk); w++; end
    kick[0] = 1'b1;
    pmode[0] = 1'b1;
    @(negedge clk);
    while (!done[0] && lat < 2000) begin
      pmode[0] = ~pmode[0];
      @(negedge clk);
      lat++;
    end
    kick[0] = 1'b0;
    pmode[0] = 1'b0;
    total++;
    if (lat !== 127) begin bad++; $display("FAIL held_latency got=%0d exp=127", lat); end
    repeat (4) begin
      @(negedge clk);
      total++;
      if (ready[0] !== 1'b1) begin bad++; $display("FAIL held_rerun ready got=%b exp=1", ready[0]); end
    end
    total++;
    if (sb.size() !== 0) begin bad++; $display("FAIL held_writes_left got=%0d exp=0", sb.size()); end
  endtask

  task automatic test_rst_mid();
    int lat, w = 0;
    logic r1;
    set_identity();
    while (!ready[0] && w < 1000) begin @(negedge clk); w++; end
    kick[0] = 1'b1;
    pmode[0] = 1'b0;
    @(negedge clk);
    kick[0] = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({ready[0], done[0], en_rA[0], en_rB[0], en_wC[0]} !== 5'b10000) begin
      bad++; $display("FAIL midrst_ctrl got=%b exp=10000", {ready[0], done[0], en_rA[0], en_rB[0], en_wC[0]});
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (ready[0] !== 1'b1) begin bad++; $display("FAIL midrst_idle got=%b exp=1", ready[0]); end
    push0(16'h0402, 16'h0C0A);
    do_run(0, 1'b0, lat, r1, w);
    total++;
    if (lat !== 127) begin bad++; $display("FAIL midrst_latency got=%0d exp=127", lat); end
    total++;
    if (sb.size() !== 0) begin bad++; $display("FAIL midrst_writes_left got=%0d exp=0", sb.size()); end
  endtask

  task automatic test_n8();
    int lat, w;
    logic r1;
    for (int t = 0; t < 3; t++) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) begin
          am[r][c] = (t == 2) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 15));
          bm[r][c] = (t == 2) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 15));
        end
      load(1);
      model(8, 4, t == 1);
      sb.push_back({1'b1, 10'h200, exp_row[0]});
      sb.push_back({1'b1, 10'h201, exp_row[1]});
      do_run(1, t == 1, lat, r1, w);
      total++;
      if (lat !== 727) begin bad++; $display("FAIL n8_latency run=%0d got=%0d exp=727", t, lat); end
      total++;
      if (sb.size() !== 0) begin bad++; $display("FAIL n8_writes_left run=%0d got=%0d exp=0", t, sb.size()); end
    end
  endtask

  initial begin
    test_reset();
    test_avg();
    test_max();
    test_back_to_back();
    test_saturation();
    test_kick_held();
    test_rst_mid();
    test_n8();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
